// File: rtl/module1_packet_detect_cmul_pipe.sv
// Pipelined complex multiplier with optional conj(B), round-half-up,
// output saturation, valid/ready back-pressure and a saturation counter.
module module1_packet_detect_cmul_pipe #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int OUT_WIDTH = 18,
  parameter int SHIFT     = 14,
  parameter int NUM_STAGE = 3
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [A_WIDTH-1:0]   a_re,
  input  logic signed [A_WIDTH-1:0]   a_im,
  input  logic signed [B_WIDTH-1:0]   b_re,
  input  logic signed [B_WIDTH-1:0]   b_im,
  input  logic                        conj_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_re,
  output logic signed [OUT_WIDTH-1:0] out_im,
  output logic                        out_ovf,
  input  logic                        sat_clr,
  output logic [15:0]                 sat_count
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int W  = PW + 2;

  localparam logic signed [W-1:0] RND =
    {{(W-1){1'b0}}, 1'b1} << (SHIFT-1);
  localparam logic signed [W-1:0] MAXV =
    {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] MINV =
    {{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Whole pipeline advances together; only a blocked output stalls it.
  logic w_en;
  assign w_en     = ap_rst | ~(out_valid & ~out_ready);
  assign in_ready = w_en;

  logic signed [PW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  assign w_p_rr = PW'(a_re) * PW'(b_re);
  assign w_p_ii = PW'(a_im) * PW'(b_im);
  assign w_p_ri = PW'(a_re) * PW'(b_im);
  assign w_p_ir = PW'(a_im) * PW'(b_re);

  logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic                 r_cj;
  logic [NUM_STAGE-1:0] r_vld;

  logic signed [W-1:0] w_sum_re, w_sum_im;
  logic signed [W-1:0] w_rnd_re, w_rnd_im;

  always_comb begin
    if (r_cj) begin
      w_sum_re = W'(r_p_rr) + W'(r_p_ii);
      w_sum_im = W'(r_p_ir) - W'(r_p_ri);
    end else begin
      w_sum_re = W'(r_p_rr) - W'(r_p_ii);
      w_sum_im = W'(r_p_ri) + W'(r_p_ir);
    end
    w_rnd_re = (w_sum_re + RND) >>> SHIFT;
    w_rnd_im = (w_sum_im + RND) >>> SHIFT;
  end

  function automatic logic [OUT_WIDTH:0] f_sat(
    input logic signed [W-1:0] v
  );
    if (v > MAXV)
      f_sat = {1'b1, MAXV[OUT_WIDTH-1:0]};
    else if (v < MINV)
      f_sat = {1'b1, MINV[OUT_WIDTH-1:0]};
    else
      f_sat = {1'b0, v[OUT_WIDTH-1:0]};
  endfunction

  logic [OUT_WIDTH:0] w_sat_re, w_sat_im;
  assign w_sat_re = f_sat(w_rnd_re);
  assign w_sat_im = f_sat(w_rnd_im);

  logic signed [OUT_WIDTH-1:0] r_re [1:NUM_STAGE-1];
  logic signed [OUT_WIDTH-1:0] r_im [1:NUM_STAGE-1];
  logic [NUM_STAGE-1:1]        r_ovf;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_vld  <= '0;
      r_p_rr <= '0;
      r_p_ii <= '0;
      r_p_ri <= '0;
      r_p_ir <= '0;
      r_cj   <= 1'b0;
      r_ovf  <= '0;
      for (int k = 1; k < NUM_STAGE; k++) begin
        r_re[k] <= '0;
        r_im[k] <= '0;
      end
    end else if (w_en) begin
      r_vld    <= {r_vld[NUM_STAGE-2:0], in_valid};
      r_p_rr   <= w_p_rr;
      r_p_ii   <= w_p_ii;
      r_p_ri   <= w_p_ri;
      r_p_ir   <= w_p_ir;
      r_cj     <= conj_b;
      r_re[1]  <= w_sat_re[OUT_WIDTH-1:0];
      r_im[1]  <= w_sat_im[OUT_WIDTH-1:0];
      r_ovf[1] <= w_sat_re[OUT_WIDTH] | w_sat_im[OUT_WIDTH];
      for (int k = 2; k < NUM_STAGE; k++) begin
        r_re[k]  <= r_re[k-1];
        r_im[k]  <= r_im[k-1];
        r_ovf[k] <= r_ovf[k-1];
      end
    end
  end

  assign out_valid = r_vld[NUM_STAGE-1];
  assign out_re    = r_re[NUM_STAGE-1];
  assign out_im    = r_im[NUM_STAGE-1];
  assign out_ovf   = r_ovf[NUM_STAGE-1];

  logic [15:0] r_cnt;

  always_ff @(posedge ap_clk) begin
    if (ap_rst)
      r_cnt <= '0;
    else if (sat_clr)
      r_cnt <= '0;
    else if (out_valid && out_ready && out_ovf && r_cnt != 16'hFFFF)
      r_cnt <= r_cnt + 16'd1;
  end

  assign sat_count = r_cnt;

endmodule

// File: tb/tb_module1_packet_detect_cmul_pipe.sv
// Bench for module1_packet_detect_cmul_pipe: directed corners plus
// random traffic against an integer reference model and scoreboard.
module tb_module1_packet_detect_cmul_pipe;

  logic               ap_clk;
  logic               ap_rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] a_re, a_im, b_re, b_im;
  logic               conj_b;
  logic               out_valid;
  logic               out_ready;
  logic signed [17:0] out_re, out_im;
  logic               out_ovf;
  logic               sat_clr;
  logic [15:0]        sat_count;

  module1_packet_detect_cmul_pipe dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_re     (a_re),
    .a_im     (a_im),
    .b_re     (b_re),
    .b_im     (b_im),
    .conj_b   (conj_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_ovf  (out_ovf),
    .sat_clr  (sat_clr),
    .sat_count(sat_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    longint re;
    longint im;
    bit     ovf;
    int     cyc;
  } exp_t;

  exp_t   q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     n_del = 0;
  int     sat_exp = 0;
  bit     lat_mode = 1'b1;
  bit     held = 1'b0;
  bit     acc = 1'b0;
  longint h_re, h_im;
  bit     h_ovf;

  task automatic chk(string tag, longint obs, longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Round half up at 2^14, then clamp to 18-bit signed.
  function automatic longint rnd_sat(longint v, inout bit ovf);
    longint r;
    r = (v + 64'sd8192) >>> 14;
    if (r > 131071) begin r = 131071; ovf = 1'b1; end
    if (r < -131072) begin r = -131072; ovf = 1'b1; end
    return r;
  endfunction

  function automatic exp_t ref_cmul(longint ar, longint ai,
                                    longint br, longint bi, bit cj);
    exp_t e;
    longint re, im;
    re = cj ? ar*br + ai*bi : ar*br - ai*bi;
    im = cj ? ai*br - ar*bi : ar*bi + ai*br;
    e.ovf = 1'b0;
    e.re  = rnd_sat(re, e.ovf);
    e.im  = rnd_sat(im, e.ovf);
    e.cyc = cyc;
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    int   nxt;
    bit   rst_edge;
    @(negedge ap_clk);
    acc = 1'b0;
    nxt = sat_exp;
    if (ap_rst) begin
      chk("rst_in_ready", in_ready, 1);
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      chk("sat_count", sat_count, sat_exp);
      if (held && out_valid) begin
        chk("hold_re", out_re, h_re);
        chk("hold_im", out_im, h_im);
        chk("hold_ovf", out_ovf, h_ovf);
      end
      held = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = q.pop_front();
          chk("out_re", out_re, e.re);
          chk("out_im", out_im, e.im);
          chk("out_ovf", out_ovf, e.ovf);
          if (lat_mode) chk("latency", cyc - e.cyc, 3);
          n_del++;
          if (e.ovf && nxt != 65535) nxt++;
        end
      end
      if (sat_clr) nxt = 0;
      if (out_valid && !out_ready) begin
        held  = 1'b1;
        h_re  = out_re;
        h_im  = out_im;
        h_ovf = out_ovf;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_cmul(a_re, a_im, b_re, b_im, conj_b));
        acc = 1'b1;
      end
    end
    rst_edge = ap_rst;
    @(posedge ap_clk);
    #1;
    cyc++;
    if (rst_edge) begin
      q.delete();
      sat_exp = 0;
      held = 1'b0;
    end else begin
      sat_exp = nxt;
    end
  endtask

  function automatic logic signed [15:0] pick();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return -16'sd32768;
    if (r == 1) return 16'sd32767;
    return 16'($urandom);
  endfunction

  task automatic rnd_in();
    a_re   = pick();
    a_im   = pick();
    b_re   = pick();
    b_im   = pick();
    conj_b = 1'($urandom);
  endtask

  task automatic directed(string tag,
                          logic signed [15:0] ar, logic signed [15:0] ai,
                          logic signed [15:0] br, logic signed [15:0] bi,
                          logic cj, longint ere, longint eim, logic eovf);
    int k;
    a_re = ar; a_im = ai; b_re = br; b_im = bi; conj_b = cj;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, k, 3);
    chk({tag, "_re"}, out_re, ere);
    chk({tag, "_im"}, out_im, eim);
    chk({tag, "_ovf"}, out_ovf, eovf);
    tick();
  endtask

  initial begin
    int sent, t, d0;
    ap_rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; sat_clr = 1'b0;
    rnd_in();
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_sat_count", sat_count, 0);
    ap_rst = 1'b0;

    directed("ident", 16384, 0, 16384, 0, 1'b0, 16384, 0, 1'b0);
    directed("rnd_up", 1, 0, 8192, 0, 1'b0, 1, 0, 1'b0);
    directed("rnd_dn", 1, 0, 8191, 0, 1'b0, 0, 0, 1'b0);
    directed("rnd_neg", -1, 0, 8192, 0, 1'b0, 0, 0, 1'b0);
    directed("sat_cj1", -32768, -32768, -32768, -32768, 1'b1,
             131071, 0, 1'b1);
    chk("sat_cnt_1", sat_count, 1);
    directed("sat_cj0", -32768, -32768, -32768, -32768, 1'b0,
             0, 131071, 1'b1);
    chk("sat_cnt_2", sat_count, 2);

    // Back-pressure: 10 beats, output blocked for 4 cycles.
    lat_mode = 1'b0;
    d0 = n_del; sent = 0; t = 0;
    rnd_in();
    while ((n_del - d0) < 10 && t < 60) begin
      out_ready = !(t >= 5 && t < 9);
      in_valid  = (sent < 10);
      tick();
      if (acc) begin sent++; rnd_in(); end
      t++;
    end
    chk("bp_delivered", n_del - d0, 10);
    chk("bp_queue_empty", q.size(), 0);

    // Random traffic with random stalls and clears.
    for (int i = 0; i < 400; i++) begin
      rnd_in();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sat_clr   = ($urandom_range(0, 31) == 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    repeat (6) tick();
    chk("rand_queue_empty", q.size(), 0);

    // Reset with three beats in flight.
    lat_mode = 1'b1;
    repeat (3) begin
      rnd_in();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    repeat (8) tick();
    chk("mid_rst_queue", q.size(), 0);
    chk("mid_rst_sat", sat_count, 0);

    // Counter saturation over 65537 saturated deliveries.
    a_re = -32768; a_im = -32768; b_re = -32768; b_im = -32768;
    conj_b = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    d0 = n_del; t = 0;
    while ((n_del - d0) < 65537 && t < 70000) begin
      tick();
      t++;
    end
    chk("cnt_deliveries", n_del - d0, 65537);
    chk("cnt_sat_ffff", sat_count, 16'hFFFF);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("cnt_clr_prio", sat_count, 0);
    in_valid = 1'b0;
    repeat (6) tick();
    chk("final_queue", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
